byte_word_packer: RTL and testbench

- Downstream consumer of the team's 8-bit registered pipeline stages.
- Accepts one byte per cycle under a valid/ready handshake and packs LANES bytes into one wide word, little-endian: the first byte goes to bits [7:0].
- An in_last flag emits a partial word early, with a lane keep mask.
- Provides a registered output with single-word buffering, so the 8-bit pipeline can feed a 32-bit datapath at full throughput.

---
 rtl/byte_word_packer_pkg.sv | 12 +
 rtl/byte_word_packer_if.sv | 28 ++
 rtl/byte_word_packer_out_reg.sv | 44 ++++
 rtl/byte_word_packer.sv | 74 +++++++
 tb/tb_byte_word_packer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/byte_word_packer_pkg.sv
// Shared definitions for the byte-to-word packer.
//   DW_DEFAULT    : default byte lane width in bits
//   LANES_DEFAULT : default bytes per output word (legal 2..8)
//   lane_idx_t    : lane index / fill counter at default geometry
//   keep_t        : lane keep mask at default geometry
package pack_pkg;
  localparam int DW_DEFAULT    = 8;
  localparam int LANES_DEFAULT = 4;

  typedef logic [$clog2(LANES_DEFAULT)-1:0] lane_idx_t;
  typedef logic [LANES_DEFAULT-1:0]         keep_t;
endpackage

// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out stream bundle for the packer.
//   in_data/in_valid/in_last/in_ready         : byte stream, valid/ready
//   out_data/out_keep/out_last/out_valid/out_ready : word stream, valid/ready
// master = producer of bytes and consumer of words; slave = the packer.
interface byte_word_packer_if #(
  parameter int DW    = pack_pkg::DW_DEFAULT,
  parameter int LANES = pack_pkg::LANES_DEFAULT
);
  logic [DW-1:0]             in_data;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
  logic [LANES-1:0][DW-1:0]  out_data;
  logic [LANES-1:0]          out_keep;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_keep, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_keep, out_last, out_valid
  );
endinterface

// File: rtl/byte_word_packer_out_reg.sv
// pack_out_reg: single-entry output holding register with valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   load, load_*        : new word to capture (only when in_ready is high)
//   out_ready           : downstream accepts the held word
//   in_ready            : register can take a new word this cycle
//   out_valid, out_*    : held word
module pack_out_reg #(
  parameter int DW    = pack_pkg::DW_DEFAULT,
  parameter int LANES = pack_pkg::LANES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [LANES-1:0][DW-1:0] load_data,
  input  logic [LANES-1:0]         load_keep,
  input  logic                     load_last,
  input  logic                     out_ready,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [LANES-1:0][DW-1:0] out_data,
  output logic [LANES-1:0]         out_keep,
  output logic                     out_last
);
  // Free when empty or draining this cycle; never depends on upstream valid,
  // so no combinational loop through the byte handshake.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      // covers drain+load in the same cycle: new word replaces old, no bubble
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_keep  <= load_keep;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs LANES bytes (little-endian, first byte in lane 0)
// into one word; in_last closes a partial word early with a keep mask.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of byte_word_packer_if (byte in, word out)
module byte_word_packer
  import pack_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int LANES = LANES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  byte_word_packer_if.slave  bus
);
  localparam int            CW        = $clog2(LANES);
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  logic [CW-1:0]            cnt, cnt_nxt;
  logic [LANES-1:0][DW-1:0] acc, acc_nxt, word;
  logic [LANES-1:0]         keep_acc, keep_nxt, lane_sel;
  logic                     accept, complete;

  assign accept   = bus.in_valid && bus.in_ready;
  assign complete = accept && (bus.in_last || cnt == LAST_LANE);

  // acc lanes at and above cnt are always zero, so inserting the byte at
  // lane cnt yields both the next accumulator and the completed word.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_sel[i] = (cnt == CW'(i));
    assign word[i]     = lane_sel[i] ? bus.in_data : acc[i];
  end

  always_comb begin
    cnt_nxt  = cnt;
    acc_nxt  = acc;
    keep_nxt = keep_acc;
    if (complete) begin
      cnt_nxt  = '0;
      acc_nxt  = '0;
      keep_nxt = '0;
    end else if (accept) begin
      cnt_nxt  = cnt + 1'b1;
      acc_nxt  = word;
      keep_nxt = keep_acc | lane_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      keep_acc <= '0;
    end else begin
      cnt      <= cnt_nxt;
      acc      <= acc_nxt;
      keep_acc <= keep_nxt;
    end
  end

  pack_out_reg #(.DW(DW), .LANES(LANES)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (complete),
    .load_data (word),
    .load_keep (keep_acc | lane_sel),
    .load_last (bus.in_last),
    .out_ready (bus.out_ready),
    .in_ready  (bus.in_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_keep  (bus.out_keep),
    .out_last  (bus.out_last)
  );
endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;
  logic clk;
  logic rst;

  byte_word_packer_if #(.DW(8), .LANES(4)) bus ();

  byte_word_packer #(.DW(8), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   stamps[$];

  logic [31:0] m_acc;
  logic [3:0]  m_keep;
  int          m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acc  = '0;
    m_keep = '0;
    m_cnt  = 0;
  endtask

  // reference packer: lane m_cnt takes the byte; word pushed on completion
  task automatic model_accept(input logic [7:0] d, input logic l);
    exp_t e;
    m_acc[8*m_cnt +: 8] = d;
    m_keep[m_cnt]       = 1'b1;
    if (l || m_cnt == 3) begin
      e.data = m_acc;
      e.keep = m_keep;
      e.last = l;
      q.push_back(e);
      model_clear();
    end else begin
      m_cnt++;
    end
  endtask

  // drive one byte until accepted (bounded), return just after the edge
  task automatic send_byte(input logic [7:0] d, input logic l);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(d, l);
        @(posedge clk); #1;
        break;
      end
      w++;
      if (w > 50) begin
        chk("in_timeout", 64'(w), 64'd0);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // scoreboard: every output transfer must match the oldest expected word
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e.data));
        chk("out_keep", 64'(bus.out_keep), 64'(e.keep));
        chk("out_last", 64'(bus.out_last), 64'(e.last));
        stamps.push_back(cyc);
      end
    end
  end

  initial begin
    int base;
    model_clear();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data",  64'(bus.out_data),  64'd0);
    chk("rst_keep",  64'(bus.out_keep),  64'd0);
    chk("rst_last",  64'(bus.out_last),  64'd0);
    chk("rst_ready", 64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;

    // full word, out_valid pulses for exactly one cycle
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    @(negedge clk);
    chk("w1_valid_hi", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    chk("w1_valid_lo", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;

    // partial word closed by in_last, then single-byte word at lane 0
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    send_byte(8'h5C, 1'b1);
    repeat (2) @(posedge clk); #1;

    // stall: word held stable, no bytes taken
    bus.out_ready = 1'b0;
    send_byte(8'hA0, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hB0;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_data",  64'(bus.out_data),  64'hA3A2A1A0);
      chk("stall_ready", 64'(bus.in_ready),  64'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1 chk("unstall_ready", 64'(bus.in_ready), 64'd1);
    send_byte(8'hB0, 1'b0);
    send_byte(8'hB1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hB3, 1'b0);
    repeat (2) @(posedge clk); #1;

    // continuous 16 bytes: words every 4 cycles, no bubbles
    base = stamps.size();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("cont_words", 64'(stamps.size() - base), 64'd4);
    if (stamps.size() - base == 4)
      for (int i = 1; i < 4; i++)
        chk("cont_gap", 64'(stamps[base+i] - stamps[base+i-1]), 64'd4);

    // reset with a stalled word pending
    bus.out_ready = 1'b0;
    send_byte(8'hD1, 1'b0);
    send_byte(8'hD2, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'hD4, 1'b0);
    do_reset();
    @(negedge clk);
    chk("rst2_valid", 64'(bus.out_valid), 64'd0);
    chk("rst2_data",  64'(bus.out_data),  64'd0);
    chk("rst2_keep",  64'(bus.out_keep),  64'd0);
    chk("rst2_ready", 64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;

    // reset mid-word: partial bytes must be discarded
    bus.out_ready = 1'b1;
    send_byte(8'hE1, 1'b0);
    send_byte(8'hE2, 1'b0);
    do_reset();
    @(negedge clk);
    chk("rst3_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    repeat (3) @(posedge clk); #1;

    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
